sprite_compositor: RTL and testbench



---
 rtl/pokemon_gfx_pkg.sv | 27 ++
 rtl/gfx_addr_gen.sv | 49 ++++
 rtl/sprite_compositor.sv | 134 +++++++++++++
 tb/tb_sprite_compositor.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/pokemon_gfx_pkg.sv
// Shared graphics constants and types for the map/sprite compositors.
// Map is 320x240 8-bit colour indices; sprites are 16x24 with 17 frames.
package pokemon_gfx_pkg;

    localparam int MAP_W      = 320;
    localparam int MAP_H      = 240;
    localparam int SPR_W      = 16;
    localparam int SPR_H      = 24;
    localparam int SPR_FRAMES = 17;
    localparam logic [7:0] TRANSP_KEY = 8'h00;

    localparam int MAP_AW  = 19;
    localparam int CHAR_AW = 13;
    localparam int COORD_W = 9;
    localparam int FRAME_W = 5;
    localparam int PIX_W   = 8;

    // Per-frame view state captured at vertical blank.
    typedef struct packed {
        logic [COORD_W-1:0] cam_x;
        logic [COORD_W-1:0] cam_y;
        logic [COORD_W-1:0] char_x;
        logic [COORD_W-1:0] char_y;
        logic [FRAME_W-1:0] frame;
    } view_t;

endpackage

// File: rtl/gfx_addr_gen.sv
// Combinational map/sprite address generator for one map-resolution pixel.
// Shared with other object compositors; all multiplies are by constants.
module gfx_addr_gen
    import pokemon_gfx_pkg::*;
(
    input  logic [COORD_W-1:0] i_mx,
    input  logic [COORD_W-1:0] i_my,
    input  logic [COORD_W-1:0] i_cam_x,
    input  logic [COORD_W-1:0] i_cam_y,
    input  logic [COORD_W-1:0] i_obj_x,
    input  logic [COORD_W-1:0] i_obj_y,
    input  logic [FRAME_W-1:0] i_frame,
    output logic [MAP_AW-1:0]  o_map_addr,
    output logic [CHAR_AW-1:0] o_char_addr,
    output logic               o_hit
);

    logic [9:0] w_sum_x;
    logic [9:0] w_sum_y;
    logic [9:0] w_wrap_x;
    logic [9:0] w_wrap_y;
    logic [9:0] w_sx;
    logic [9:0] w_sy;
    logic       w_in_x;
    logic       w_in_y;
    logic       w_frame_ok;

    // Camera offsets are below the map size, so one subtract wraps the sum.
    assign w_sum_x  = {1'b0, i_mx} + {1'b0, i_cam_x};
    assign w_sum_y  = {1'b0, i_my} + {1'b0, i_cam_y};
    assign w_wrap_x = (w_sum_x >= 10'(MAP_W)) ? (w_sum_x - 10'(MAP_W)) : w_sum_x;
    assign w_wrap_y = (w_sum_y >= 10'(MAP_H)) ? (w_sum_y - 10'(MAP_H)) : w_sum_y;

    assign o_map_addr = (MAP_AW'(w_wrap_y) * MAP_AW'(MAP_W)) + MAP_AW'(w_wrap_x);

    // Two's-complement offsets into the sprite; bit 9 set means left/above it.
    assign w_sx = {1'b0, i_mx} - {1'b0, i_obj_x};
    assign w_sy = {1'b0, i_my} - {1'b0, i_obj_y};

    assign w_in_x     = !w_sx[9] && (w_sx[8:0] < 9'(SPR_W));
    assign w_in_y     = !w_sy[9] && (w_sy[8:0] < 9'(SPR_H));
    assign w_frame_ok = (i_frame < FRAME_W'(SPR_FRAMES));
    assign o_hit      = w_in_x && w_in_y && w_frame_ok;

    assign o_char_addr = (CHAR_AW'(i_frame) * CHAR_AW'(SPR_W * SPR_H))
                       + (CHAR_AW'(w_sy[8:0]) * CHAR_AW'(SPR_W))
                       + CHAR_AW'(w_sx[8:0]);

endmodule

// File: rtl/sprite_compositor.sv
// Three-stage compositor: overlays one animated sprite on a scrolling tile
// map at 2x scale, one pixel per clock, fixed 3-cycle latency.
module sprite_compositor
    import pokemon_gfx_pkg::*;
(
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic               pix_valid,
    input  logic [9:0]         DrawX,
    input  logic [9:0]         DrawY,
    input  logic               frame_start,
    input  logic [COORD_W-1:0] cam_x,
    input  logic [COORD_W-1:0] cam_y,
    input  logic [COORD_W-1:0] char_x,
    input  logic [COORD_W-1:0] char_y,
    input  logic [FRAME_W-1:0] char_frame,
    output logic [MAP_AW-1:0]  map_addr,
    input  logic [PIX_W-1:0]   map_data,
    output logic [CHAR_AW-1:0] char_addr,
    input  logic [PIX_W-1:0]   char_data,
    output logic               out_valid,
    output logic [PIX_W-1:0]   pix_color,
    output logic               in_sprite
);

    // Stream protocol: pix_valid qualifies DrawX/DrawY on every cycle with no
    // backpressure; out_valid follows it exactly 3 cycles later, and both RAMs
    // return data the cycle after their address is registered.

    view_t               r_view;
    view_t               w_live;
    view_t               w_view;
    logic [MAP_AW-1:0]   r_map_addr;
    logic [CHAR_AW-1:0]  r_char_addr;
    logic                r_v1;
    logic                r_hit1;
    logic                r_v2;
    logic                r_hit2;
    logic                r_out_valid;
    logic [PIX_W-1:0]    r_pix_color;
    logic                r_in_sprite;
    logic [MAP_AW-1:0]   w_map_addr;
    logic [CHAR_AW-1:0]  w_char_addr;
    logic                w_hit;
    logic                w_use_spr;
    logic                w_unused_lsb;

    assign w_live = '{cam_x: cam_x, cam_y: cam_y, char_x: char_x,
                      char_y: char_y, frame: char_frame};

    // A pixel arriving with frame_start already sees the new view.
    assign w_view = frame_start ? w_live : r_view;

    assign w_unused_lsb = DrawX[0] ^ DrawY[0];

    gfx_addr_gen u_addr_gen (
        .i_mx        (DrawX[9:1]),
        .i_my        (DrawY[9:1]),
        .i_cam_x     (w_view.cam_x),
        .i_cam_y     (w_view.cam_y),
        .i_obj_x     (w_view.char_x),
        .i_obj_y     (w_view.char_y),
        .i_frame     (w_view.frame),
        .o_map_addr  (w_map_addr),
        .o_char_addr (w_char_addr),
        .o_hit       (w_hit)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_view <= '0;
        end else if (frame_start) begin
            r_view <= w_live;
        end
    end

    // Stage 1: RAM addresses; char_addr only moves on a sprite hit.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_v1        <= 1'b0;
            r_hit1      <= 1'b0;
            r_map_addr  <= '0;
            r_char_addr <= '0;
        end else begin
            r_v1   <= pix_valid;
            r_hit1 <= pix_valid && w_hit;
            if (pix_valid) begin
                r_map_addr <= w_map_addr;
            end
            if (pix_valid && w_hit) begin
                r_char_addr <= w_char_addr;
            end
        end
    end

    // Stage 2: qualifiers travel with the RAM read.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_v2   <= 1'b0;
            r_hit2 <= 1'b0;
        end else begin
            r_v2   <= r_v1;
            r_hit2 <= r_hit1;
        end
    end

    assign w_use_spr = r_hit2 && (char_data != TRANSP_KEY);

    // Stage 3: select and register the final colour; idle slots output zero.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_out_valid <= 1'b0;
            r_pix_color <= '0;
            r_in_sprite <= 1'b0;
        end else begin
            r_out_valid <= r_v2;
            r_in_sprite <= r_v2 && w_use_spr;
            if (!r_v2) begin
                r_pix_color <= '0;
            end else if (w_use_spr) begin
                r_pix_color <= char_data;
            end else begin
                r_pix_color <= map_data;
            end
        end
    end

    assign map_addr  = r_map_addr;
    assign char_addr = r_char_addr;
    assign out_valid = r_out_valid;
    assign pix_color = r_pix_color;
    assign in_sprite = r_in_sprite;

endmodule

// File: tb/tb_sprite_compositor.sv
// Directed bench for sprite_compositor with behavioural map/char RAMs that
// return data one cycle after the address.
module tb_sprite_compositor;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        pix_valid;
    logic [9:0]  DrawX;
    logic [9:0]  DrawY;
    logic        frame_start;
    logic [8:0]  cam_x;
    logic [8:0]  cam_y;
    logic [8:0]  char_x;
    logic [8:0]  char_y;
    logic [4:0]  char_frame;
    logic [18:0] map_addr;
    logic [7:0]  map_data;
    logic [12:0] char_addr;
    logic [7:0]  char_data;
    logic        out_valid;
    logic [7:0]  pix_color;
    logic        in_sprite;

    logic [7:0] map_mem  [0:76799];
    logic [7:0] char_mem [0:8191];

    int total = 0;
    int bad   = 0;

    always #5 Clk = ~Clk;

    always @(posedge Clk) begin
        map_data  <= map_mem[map_addr];
        char_data <= char_mem[char_addr];
    end

    sprite_compositor dut (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .pix_valid   (pix_valid),
        .DrawX       (DrawX),
        .DrawY       (DrawY),
        .frame_start (frame_start),
        .cam_x       (cam_x),
        .cam_y       (cam_y),
        .char_x      (char_x),
        .char_y      (char_y),
        .char_frame  (char_frame),
        .map_addr    (map_addr),
        .map_data    (map_data),
        .char_addr   (char_addr),
        .char_data   (char_data),
        .out_valid   (out_valid),
        .pix_color   (pix_color),
        .in_sprite   (in_sprite)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_view(input int cx, input int cy, input int sx, input int sy, input int fr, input logic fs);
        cam_x       = 9'(cx);
        cam_y       = 9'(cy);
        char_x      = 9'(sx);
        char_y      = 9'(sy);
        char_frame  = 5'(fr);
        frame_start = fs;
    endtask

    // One isolated pixel: addresses after 1 cycle, colour after 3, then a bubble.
    task automatic run_pix(input string tag, input int x, input int y, input int e_map,
                           input int e_char, input int e_col, input int e_spr);
        pix_valid = 1'b1;
        DrawX     = 10'(x);
        DrawY     = 10'(y);
        @(negedge Clk);
        frame_start = 1'b0;
        pix_valid   = 1'b0;
        chk({tag, "_map_addr"}, 32'(map_addr), e_map);
        chk({tag, "_char_addr"}, 32'(char_addr), e_char);
        @(negedge Clk);
        @(negedge Clk);
        chk({tag, "_out_valid"}, 32'(out_valid), 1);
        chk({tag, "_pix_color"}, 32'(pix_color), e_col);
        chk({tag, "_in_sprite"}, 32'(in_sprite), e_spr);
        @(negedge Clk);
        chk({tag, "_idle_valid"}, 32'(out_valid), 0);
        chk({tag, "_idle_color"}, 32'(pix_color), 0);
    endtask

    initial begin
        for (int i = 0; i < 76800; i++) map_mem[i] = 8'h00;
        for (int i = 0; i < 8192; i++) char_mem[i] = 8'h00;
        for (int k = 0; k < 10; k++) map_mem[k] = 8'hA0 + 8'(k);
        map_mem[16100]  = 8'h55;
        map_mem[3230]   = 8'h77;
        map_mem[16693]  = 8'hC3;
        char_mem[0]     = 8'h3C;
        char_mem[6144]  = 8'h21;
        char_mem[6527]  = 8'h9E;

        Reset_n   = 1'b0;
        pix_valid = 1'b0;
        DrawX     = '0;
        DrawY     = '0;
        set_view(0, 0, 0, 0, 0, 1'b0);
        repeat (3) @(negedge Clk);
        chk("rst_map_addr", 32'(map_addr), 0);
        chk("rst_char_addr", 32'(char_addr), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_pix_color", 32'(pix_color), 0);
        chk("rst_in_sprite", 32'(in_sprite), 0);
        Reset_n = 1'b1;
        @(negedge Clk);

        // Opaque sprite pixel at the sprite origin, view loaded with the pixel.
        set_view(0, 0, 100, 50, 0, 1'b1);
        run_pix("spr_opaque", 200, 100, 16100, 0, 8'h3C, 1);

        // Same pixel, transparent sprite data shows the map.
        char_mem[0] = 8'h00;
        run_pix("spr_transp", 200, 100, 16100, 0, 8'h55, 0);

        // Outside the sprite: map only, char_addr holds.
        run_pix("outside", 0, 0, 0, 0, 8'hA0, 0);

        // Camera wrap in both axes.
        set_view(300, 230, 100, 50, 0, 1'b1);
        run_pix("cam_wrap", 100, 40, 3230, 0, 8'h77, 0);

        // Last valid frame, bottom-right sprite pixel.
        set_view(0, 0, 100, 50, 16, 1'b1);
        run_pix("frame16_corner", 230, 146, 23475, 6527, 8'h9E, 1);

        // Inputs change without frame_start: old view still used.
        set_view(0, 0, 50, 50, 0, 1'b0);
        run_pix("no_reload", 200, 100, 16100, 6144, 8'h21, 1);

        // New view takes effect with the next frame_start.
        set_view(0, 0, 50, 50, 0, 1'b1);
        run_pix("reload", 106, 104, 16693, 35, 8'hC3, 0);

        // Out-of-range frame hides the sprite and leaves char_addr alone.
        set_view(0, 0, 100, 50, 17, 1'b1);
        run_pix("frame17_hidden", 200, 100, 16100, 35, 8'h55, 0);

        // Back-to-back stream with reset pulsed while the 5th pixel is driven.
        for (int k = 0; k < 13; k++) begin
            if (k >= 3) begin
                if (k - 3 >= 2 && k - 3 <= 4) begin
                    chk($sformatf("stream%0d_dropped_valid", k - 3), 32'(out_valid), 0);
                    chk($sformatf("stream%0d_dropped_color", k - 3), 32'(pix_color), 0);
                end else begin
                    chk($sformatf("stream%0d_valid", k - 3), 32'(out_valid), 1);
                    chk($sformatf("stream%0d_color", k - 3), 32'(pix_color), 32'(8'hA0 + 8'(k - 3)));
                    chk($sformatf("stream%0d_in_sprite", k - 3), 32'(in_sprite), 0);
                end
            end
            if (k == 4) Reset_n = 1'b0;
            if (k == 5) Reset_n = 1'b1;
            if (k < 10) begin
                pix_valid = 1'b1;
                DrawX     = 10'(2 * k);
                DrawY     = 10'd0;
            end else begin
                pix_valid = 1'b0;
            end
            @(negedge Clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
